// File: rtl/mem_access_ctrl.sv
// Shares the single RAM port between instruction fetch and load/store.
// Round-robin arbitration, MOV/MOC handshake with timeout, alignment check, zero-extended reads.
module mem_access_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        if_req,
    input  logic [7:0]  if_addr,
    output logic        if_ack,
    output logic        if_err,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_dt,
    input  logic [7:0]  ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_ack,
    output logic        ls_err,
    output logic [31:0] rd_data,
    output logic [7:0]  mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_rw,
    output logic        mem_mov,
    output logic [1:0]  mem_dt,
    input  logic [31:0] mem_rdata,
    input  logic        mem_moc
);

    localparam int unsigned CNT_W = 8;
    localparam logic [1:0] DT_BYTE = 2'b00;
    localparam logic [1:0] DT_HALF = 2'b01;
    localparam logic [1:0] DT_WORD = 2'b10;
    localparam logic [1:0] DT_ILL  = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE,
        ERR,
        RELEASE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             last_grant;   // 1 = load/store was granted last
    logic             owner;        // 1 = load/store owns the port
    logic             owner_next;
    logic             grant;
    logic             grant_ls;
    logic             grant_bad;
    logic [1:0]       grant_dt;
    logic [7:0]       grant_addr;
    logic             ack_next;
    logic             err_next;

    function automatic logic [31:0] mask_rd(input logic [1:0] dt, input logic [31:0] d);
        case (dt)
            DT_BYTE: mask_rd = {24'b0, d[7:0]};
            DT_HALF: mask_rd = {16'b0, d[15:0]};
            default: mask_rd = d;
        endcase
    endfunction

    // Next-state, arbitration and alignment decode
    always_comb begin
        state_next = state;
        owner_next = owner;
        grant      = 1'b0;
        grant_ls   = 1'b0;
        grant_bad  = 1'b0;
        grant_dt   = DT_WORD;
        grant_addr = if_addr;
        case (state)
            IDLE: begin
                if (if_req || ls_req) begin
                    grant      = 1'b1;
                    grant_ls   = ls_req && (!if_req || !last_grant);
                    owner_next = grant_ls;
                    grant_dt   = grant_ls ? ls_dt : DT_WORD;
                    grant_addr = grant_ls ? ls_addr : if_addr;
                    grant_bad  = (grant_dt == DT_ILL)
                              || (grant_dt == DT_HALF && grant_addr[0])
                              || (grant_dt == DT_WORD && grant_addr[1:0] != 2'b00);
                    state_next = grant_bad ? ERR : SETUP;
                end
            end
            SETUP:   state_next = ACCESS;
            ACCESS: begin
                if (mem_moc)
                    state_next = DONE;
                else if (cnt == CNT_W'(TIMEOUT - 1))
                    state_next = ERR;
            end
            DONE:    state_next = RELEASE;
            ERR:     state_next = RELEASE;
            RELEASE: if (!mem_moc) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign ack_next = (state_next == DONE) || (state_next == ERR);
    assign err_next = (state_next == ERR);

    always_ff @(posedge clk) begin
        if (clr) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            rd_data    <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_dt     <= '0;
            mem_rw     <= 1'b1;
            mem_mov    <= 1'b0;
            if_ack     <= 1'b0;
            if_err     <= 1'b0;
            ls_ack     <= 1'b0;
            ls_err     <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= (state == ACCESS) ? cnt + CNT_W'(1) : '0;
            owner   <= owner_next;
            mem_mov <= (state_next == ACCESS);
            if_ack  <= ack_next && !owner_next;
            if_err  <= err_next && !owner_next;
            ls_ack  <= ack_next && owner_next;
            ls_err  <= err_next && owner_next;
            if (grant) begin
                last_grant <= grant_ls;
                // Memory-facing registers only change for an access that will reach the RAM
                if (!grant_bad) begin
                    mem_addr <= grant_addr;
                    mem_dt   <= grant_dt;
                    mem_rw   <= grant_ls ? !ls_we : 1'b1;
                    if (grant_ls)
                        mem_wdata <= ls_wdata;
                end
            end
            if (state == ACCESS && mem_moc && mem_rw)
                rd_data <= mask_rd(mem_dt, mem_rdata);
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a small MOV/MOC responder (TIMEOUT = 4).
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        clr;
    logic        if_req;
    logic [7:0]  if_addr;
    logic        if_ack;
    logic        if_err;
    logic        ls_req;
    logic        ls_we;
    logic [1:0]  ls_dt;
    logic [7:0]  ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_ack;
    logic        ls_err;
    logic [31:0] rd_data;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rw;
    logic        mem_mov;
    logic [1:0]  mem_dt;
    logic [31:0] mem_rdata;
    logic        mem_moc;

    int n_assert = 0;
    int n_fail   = 0;

    // RAM responder: MOC in the moc_delay-th cycle of MOV when enabled, or forced high
    logic moc_en;
    logic moc_hold;
    int   moc_delay;
    int   acc_n = 0;

    always @(posedge clk) acc_n <= mem_mov ? acc_n + 1 : 0;
    assign mem_moc = moc_hold | (moc_en & mem_mov & ((acc_n + 1) >= moc_delay));

    always #5 clk = ~clk;

    mem_access_ctrl #(.TIMEOUT(4)) dut (
        .clk       (clk),
        .clr       (clr),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ack    (if_ack),
        .if_err    (if_err),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_dt     (ls_dt),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_ack    (ls_ack),
        .ls_err    (ls_err),
        .rd_data   (rd_data),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rw    (mem_rw),
        .mem_mov   (mem_mov),
        .mem_dt    (mem_dt),
        .mem_rdata (mem_rdata),
        .mem_moc   (mem_moc)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        clr = 1'b1;
        tick();
        tick();
        clr = 1'b0;
    endtask

    // Misaligned/illegal load: error ack one cycle after request, no memory cycle
    task automatic misalign(input string tag, input logic [1:0] dt, input logic [7:0] addr,
                            input logic [31:0] rd_keep);
        ls_req  = 1'b1;
        ls_we   = 1'b0;
        ls_dt   = dt;
        ls_addr = addr;
        tick();
        chk({tag, "_ack"}, 32'(ls_ack), 32'd1);
        chk({tag, "_err"}, 32'(ls_err), 32'd1);
        chk({tag, "_mov"}, 32'(mem_mov), 32'd0);
        chk({tag, "_rd"}, rd_data, rd_keep);
        ls_req = 1'b0;
        tick();
        chk({tag, "_rel_mov"}, 32'(mem_mov), 32'd0);
        chk({tag, "_rel_ack"}, 32'(ls_ack), 32'd0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr       = 1'b1;
        if_req    = 1'b0;
        if_addr   = 8'h00;
        ls_req    = 1'b0;
        ls_we     = 1'b0;
        ls_dt     = 2'b00;
        ls_addr   = 8'h00;
        ls_wdata  = 32'h0;
        mem_rdata = 32'h0;
        moc_en    = 1'b1;
        moc_hold  = 1'b0;
        moc_delay = 1;

        // Reset values
        do_reset();
        chk("rst_rd_data", rd_data, 32'h0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_mem_dt", 32'(mem_dt), 32'h0);
        chk("rst_mem_rw", 32'(mem_rw), 32'd1);
        chk("rst_mem_mov", 32'(mem_mov), 32'd0);
        chk("rst_acks", {28'h0, if_ack, if_err, ls_ack, ls_err}, 32'h0);

        // Load word at 0x04, MOC on 2nd ACCESS cycle
        ls_req = 1'b1; ls_we = 1'b0; ls_dt = 2'b10; ls_addr = 8'h04;
        mem_rdata = 32'hDEADBEEF; moc_delay = 2;
        tick();
        chk("lw_setup_mov", 32'(mem_mov), 32'd0);
        chk("lw_setup_addr", 32'(mem_addr), 32'h04);
        chk("lw_setup_rw", 32'(mem_rw), 32'd1);
        tick();
        chk("lw_acc1_mov", 32'(mem_mov), 32'd1);
        tick();
        chk("lw_acc2_mov", 32'(mem_mov), 32'd1);
        chk("lw_acc2_ack", 32'(ls_ack), 32'd0);
        tick();
        chk("lw_ack", 32'(ls_ack), 32'd1);
        chk("lw_err", 32'(ls_err), 32'd0);
        chk("lw_done_mov", 32'(mem_mov), 32'd0);
        chk("lw_rd_data", rd_data, 32'hDEADBEEF);
        chk("lw_if_ack", 32'(if_ack), 32'd0);
        ls_req = 1'b0;
        tick();
        chk("lw_rel_ack", 32'(ls_ack), 32'd0);
        tick();

        // Store halfword 0x1234ABCD at 0x12; inputs scrambled after grant
        ls_req = 1'b1; ls_we = 1'b1; ls_dt = 2'b01; ls_addr = 8'h12;
        ls_wdata = 32'h1234ABCD; moc_delay = 1;
        tick();
        ls_addr = 8'hFF; ls_wdata = 32'h0; ls_dt = 2'b11; ls_we = 1'b0;
        tick();
        chk("sh_mov", 32'(mem_mov), 32'd1);
        chk("sh_rw", 32'(mem_rw), 32'd0);
        chk("sh_dt", 32'(mem_dt), 32'h1);
        chk("sh_addr", 32'(mem_addr), 32'h12);
        chk("sh_wdata", mem_wdata, 32'h1234ABCD);
        tick();
        chk("sh_ack", 32'(ls_ack), 32'd1);
        chk("sh_err", 32'(ls_err), 32'd0);
        chk("sh_rd_keep", rd_data, 32'hDEADBEEF);
        ls_req = 1'b0;
        tick();
        tick();

        // Load byte returning 0xFFFFFF80
        ls_req = 1'b1; ls_we = 1'b0; ls_dt = 2'b00; ls_addr = 8'h13;
        mem_rdata = 32'hFFFFFF80;
        tick();
        tick();
        chk("lb_dt", 32'(mem_dt), 32'h0);
        tick();
        chk("lb_ack", 32'(ls_ack), 32'd1);
        chk("lb_rd_data", rd_data, 32'h00000080);
        ls_req = 1'b0;
        tick();
        tick();

        // Round-robin from reset: fetch, load/store, fetch with acks 5 cycles apart
        do_reset();
        if_req = 1'b1; if_addr = 8'h20;
        ls_req = 1'b1; ls_we = 1'b0; ls_dt = 2'b10; ls_addr = 8'h08;
        mem_rdata = 32'hCAFEF00D; moc_delay = 1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            chk($sformatf("rr_if_ack_c%0d", c), 32'(if_ack), 32'((c == 3) || (c == 13)));
            chk($sformatf("rr_ls_ack_c%0d", c), 32'(ls_ack), 32'(c == 8));
            if (c == 2)  chk("rr_addr_fetch", 32'(mem_addr), 32'h20);
            if (c == 7)  chk("rr_addr_ls", 32'(mem_addr), 32'h08);
            if (c == 13) chk("rr_rd_data", rd_data, 32'hCAFEF00D);
        end
        if_req = 1'b0;
        ls_req = 1'b0;
        tick();

        // Misaligned word, illegal dt, misaligned halfword
        misalign("mis_word", 2'b10, 8'h06, 32'hCAFEF00D);
        misalign("mis_ill", 2'b11, 8'h00, 32'hCAFEF00D);
        misalign("mis_half", 2'b01, 8'h03, 32'hCAFEF00D);

        // Timeout on a fetch: MOV high exactly 4 cycles, then error ack
        if_req = 1'b1; if_addr = 8'h40; moc_en = 1'b0;
        tick();
        chk("to_setup_mov", 32'(mem_mov), 32'd0);
        for (int c = 2; c <= 5; c++) begin
            tick();
            chk($sformatf("to_mov_c%0d", c), 32'(mem_mov), 32'd1);
        end
        tick();
        chk("to_mov_end", 32'(mem_mov), 32'd0);
        chk("to_if_ack", 32'(if_ack), 32'd1);
        chk("to_if_err", 32'(if_err), 32'd1);
        chk("to_ls_ack", 32'(ls_ack), 32'd0);
        chk("to_rd_keep", rd_data, 32'hCAFEF00D);
        // MOC stuck high holds RELEASE; pending load must wait for MOC low
        if_req = 1'b0; moc_hold = 1'b1; moc_en = 1'b1;
        ls_req = 1'b1; ls_we = 1'b0; ls_dt = 2'b10; ls_addr = 8'h0C;
        mem_rdata = 32'h11223344;
        for (int c = 7; c <= 13; c++) begin
            tick();
            if (c == 9) moc_hold = 1'b0;
            chk($sformatf("to_rel_mov_c%0d", c), 32'(mem_mov), 32'(c == 12));
            chk($sformatf("to_rel_ls_ack_c%0d", c), 32'(ls_ack), 32'(c == 13));
        end
        chk("to_next_rd", rd_data, 32'h11223344);
        ls_req = 1'b0;
        tick();
        tick();

        // Reset during 2nd ACCESS cycle of a fetch, load/store request arrives with it
        if_req = 1'b1; if_addr = 8'h24; moc_en = 1'b0;
        tick();
        tick();
        tick();
        chk("rm_acc2_mov", 32'(mem_mov), 32'd1);
        clr = 1'b1;
        ls_req = 1'b1; ls_we = 1'b0; ls_dt = 2'b10; ls_addr = 8'h08;
        mem_rdata = 32'h55667788;
        tick();
        chk("rm_mov", 32'(mem_mov), 32'd0);
        chk("rm_if_ack", 32'(if_ack), 32'd0);
        chk("rm_ls_ack", 32'(ls_ack), 32'd0);
        chk("rm_rd_data", rd_data, 32'h0);
        chk("rm_rw", 32'(mem_rw), 32'd1);
        clr = 1'b0; moc_en = 1'b1;
        tick();
        chk("rm_grant_addr", 32'(mem_addr), 32'h24);
        tick();
        chk("rm_acc_mov", 32'(mem_mov), 32'd1);
        tick();
        chk("rm_if_ack_after", 32'(if_ack), 32'd1);
        chk("rm_ls_ack_after", 32'(ls_ack), 32'd0);
        chk("rm_rd_after", rd_data, 32'h55667788);
        if_req = 1'b0;
        for (int c = 8; c <= 12; c++) begin
            tick();
            chk($sformatf("rm_ls_ack_c%0d", c), 32'(ls_ack), 32'(c == 12));
        end
        ls_req = 1'b0;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory access controller that shares the single `ram256x8` port between the instruction-fetch path and the load/store path of the CPU. It arbitrates between the two requesters and drives the address and write data that feed MAR/MDR. It sequences the `MOV`/`MOC` handshake with a timeout, checks alignment, and returns zero-extended read data with a one-cycle acknowledge.

## Interface
Parameters:
- `TIMEOUT`, default 16: maximum number of cycles `mem_mov` stays high waiting for `mem_moc`. Legal range 2..255.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge
- `clr`  in  1  reset, synchronous and active-high
- `if_req`  in  1  fetch request, level; held until `if_ack`
- `if_addr`  in  8  fetch byte address
- `if_ack`  out  1  one-cycle pulse: fetch finished; `rd_data` valid when `if_err`=0
- `if_err`  out  1  qualifies `if_ack`: fetch timed out or was misaligned
- `ls_req`  in  1  load/store request, level; held until `ls_ack`
- `ls_we`  in  1  1 = store, 0 = load
- `ls_dt`  in  2  data type: 00 byte, 01 halfword, 10 word, 11 illegal
- `ls_addr`  in  8  load/store byte address
- `ls_wdata`  in  32  store data, right-aligned
- `ls_ack`  out  1  one-cycle pulse: load/store finished
- `ls_err`  out  1  qualifies `ls_ack`: timeout, misaligned access or illegal `ls_dt`
- `rd_data`  out  32  registered read data, zero-extended per data type
- `mem_addr`  out  8  address to MAR
- `mem_wdata`  out  32  store data to MDR
- `mem_rw`  out  1  R_W: 1 = read, 0 = write
- `mem_mov`  out  1  MOV: memory operation valid
- `mem_dt`  out  2  DT to RAM
- `mem_rdata`  in  32  RAM output
- `mem_moc`  in  1  MOC: memory operation complete

## Operation
- **States:** IDLE, SETUP, ACCESS, DONE, ERR, RELEASE.
- **IDLE, grant:** IDLE grants when either request is high.
  - Grant latches owner, address, write data, `we` and `dt`. A fetch is always a word read (`dt`=10, `we`=0).
  - After grant, requester inputs other than `req` are don't-care.
- **Arbitration:** round-robin on a `last_grant` bit.
  - On a tie, grant the requester not granted last.
  - A lone requester is always granted.
  - `last_grant` resets to load/store, so fetch wins the first tie after reset.
- **Alignment check at grant:**
  - Halfword needs addr[0]=0. Word needs addr[1:0]=00.
  - Misaligned access or `dt`=11 goes IDLE→ERR directly; no memory cycle occurs.
- **SETUP:** `mem_addr`/`mem_wdata`/`mem_rw`/`mem_dt` are driven from the latched values with `mem_mov`=0. Lasts one cycle, then ACCESS.
- **ACCESS:** `mem_mov`=1; the timeout counter increments each cycle.
  - `mem_moc`=1 sampled → DONE. For reads, `rd_data` captures `mem_rdata` masked by `dt`: byte {24'b0,[7:0]}, half {16'b0,[15:0]}, word [31:0].
  - Else, if the counter equals `TIMEOUT`-1 → ERR.
- **DONE:** `mem_mov`=0; owner's ack=1, err=0 → RELEASE.
- **ERR:** `mem_mov`=0; owner's ack=1, err=1; `rd_data` unchanged → RELEASE.
- **RELEASE:** `mem_mov`=0; stay until `mem_moc`=0, then → IDLE. No timeout applies.
- **Address/data hold:** `mem_addr`, `mem_wdata`, `mem_rw`, `mem_dt` hold their latched values from SETUP through RELEASE, and while IDLE.
- **Non-owner:** the non-owner's ack/err stay 0 at all times.

## Timing
- **Reset values (`clr`=1 at an edge):**
  - State=IDLE; counter=0; `last_grant`=load/store.
  - `rd_data`=0, `mem_addr`=0, `mem_wdata`=0, `mem_dt`=0, `mem_rw`=1.
  - `mem_mov`, `if_ack`, `if_err`, `ls_ack`, `ls_err` all 0.
- **Reset mid-operation:** abandons the access; no ack is issued and `mem_mov` is 0 in the next cycle.
- **Outputs:** all are registered or decoded from registered state; none are combinational from inputs.
- **Best-case latency:** `req` high in cycle 0 (IDLE) → SETUP in cycle 1 → ACCESS in cycle 2 with `mem_moc`=1 → ack in cycle 3.
  - Ack occurs 3 + (k−1) cycles after request when MOC arrives in the k-th ACCESS cycle.
  - Minimum spacing between accesses is 5 cycles.
- **Misaligned/illegal access:** ack with err in cycle 1.
- **Timeout:** `mem_mov` is high for exactly `TIMEOUT` cycles, then ERR.
- **Requester rule:** requesters deassert `req` the cycle after seeing ack. Because RELEASE lasts ≥1 cycle, a `req` still high back in IDLE is a new request.
- **MOC outside ACCESS:** `mem_moc` high while in IDLE/SETUP is ignored. In SETUP it does not shorten the access; ACCESS still lasts ≥1 cycle.

## Test plan
- **Load word:** reset, then load word at addr 0x04 with RAM returning 0xDEADBEEF and MOC on the 2nd ACCESS cycle → `mem_mov` high 2 cycles, `ls_ack` 4 cycles after `ls_req`, `rd_data`=0xDEADBEEF, `ls_err`=0.
- **Store halfword:** store halfword 0x1234ABCD at addr 0x12 → `mem_rw`=0, `mem_dt`=01, `mem_addr`=0x12, `mem_wdata`=0x1234ABCD during ACCESS. Load byte returning 0xFFFFFF80 → `rd_data`=0x00000080.
- **Round-robin:** `if_req` and `ls_req` asserted together after reset and held, with immediate MOC → order is fetch, load/store, fetch. Acks are 5 cycles apart, and the two acks never coincide.
- **Misaligned access:** word load at 0x06, and `ls_dt`=11 at 0x00 → `ls_ack`+`ls_err` in cycle 1, `mem_mov` never asserted, `rd_data` unchanged.
- **Timeout:** `TIMEOUT`=4, MOC never asserted on a fetch → `mem_mov` high exactly 4 cycles, then `if_ack`=`if_err`=1. MOC then held high 3 extra cycles → controller stays in RELEASE and the next grant waits for MOC low.
- **Reset mid-access:** `clr` pulsed in the 2nd ACCESS cycle → next cycle `mem_mov`=0, no ack, `rd_data`=0, `mem_rw`=1. With both requests pending, fetch is granted first.
